rr_arbiter16: RTL and testbench
===============================

RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 Parameter MAX_HOLD, default 64, SHALL set the maximum grant tenure in clock cycles (range 1..255); it is used only when RR_TIMEOUT_EN is defined.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port req, input, 16, SHALL carry level request lines, where bit i is requester i.
REQ-005 Port release, input, 1, SHALL be a one-cycle pulse from the current holder ending its tenure.
REQ-006 Port gnt_valid, output, 1, SHALL be high while a grant is held.
REQ-007 Port gnt_id, output, 4, SHALL give the binary index of the holder; 4'd0 when gnt_valid is low.
REQ-008 Port gnt_onehot, output, 16, SHALL give the one-hot form of gnt_id; all zeros when gnt_valid is low.
REQ-009 Port timeout, output, 1, SHALL be a one-cycle pulse when a grant is force-revoked.
REQ-010 All outputs SHALL be registered; no combinational path from input to output.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE, and the pointer SHALL be unchanged.
REQ-013 In IDLE with req != 0, the winner SHALL be the first set bit found searching downward from ptr, wrapping 0 -> 15.
- The next cycle SHALL enter GRANT with gnt_valid=1 and gnt_id=winner (1-cycle latency).
REQ-014 On each grant to index k, ptr SHALL be set to (k-1) mod 16, so that k has the lowest priority in the next arbitration.
REQ-015 In GRANT, gnt_id and gnt_onehot SHALL hold stable regardless of other req bits.
REQ-016 In GRANT, release=1 SHALL end the tenure: next cycle IDLE with gnt_valid=0.
- There SHALL always be at least one idle cycle between grants.
REQ-017 In GRANT, if req[gnt_id] drops to 0, the block SHALL treat it identically to release.
- This is not a timeout; timeout SHALL stay 0.
REQ-018 release asserted in IDLE SHALL be ignored.
REQ-019 release and a holder req drop in the same cycle SHALL produce a single end of tenure.
REQ-020 A new req edge arriving in the same cycle as release SHALL be arbitrated in the following IDLE cycle, not in that same cycle.
REQ-021 With all 16 bits requesting and every tenure released, grants SHALL cycle 15,14,...,0,15 (starvation-free; any requester waits at most 15 tenures).

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL enter IDLE, with:
- gnt_valid=0, gnt_id=0, gnt_onehot=0, timeout=0
- ptr=15
- hold counter=0
REQ-023 Reset asserted during GRANT SHALL drop the grant on that edge, with no timeout pulse.
REQ-024 After reset, the first arbitration SHALL give priority to the highest index, matching the team's priority encoder.

Configuration
REQ-025 Macro RR_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on grant entry and increment each GRANT cycle.
- When the holder has held for MAX_HOLD cycles without ending its tenure, the grant SHALL be revoked: next cycle IDLE, and timeout=1 for exactly that one cycle.
- ptr SHALL advance as normal.
REQ-026 If release and the timeout limit coincide in the same cycle, release SHALL win and timeout SHALL stay 0.
REQ-027 Macro RR_TIMEOUT_EN undefined: no counter SHALL be present, timeout SHALL be tied to 0, and a grant SHALL be held indefinitely.

Verification
REQ-028 Reset, then req=16'h8001 -> gnt_id=15 one cycle later; pulse release -> idle cycle -> gnt_id=0.
REQ-029 req=16'hFFFF with release pulsed every grant -> gnt_id sequence 15,14,...,0,15, with one idle cycle between each grant.
REQ-030 Grant held on id 5 while req toggles bits 2 and 9 -> gnt_id stays 5 until release.
REQ-031 Holder 7 drops req[7] with no release -> gnt_valid=0 next cycle, timeout=0.
REQ-032 RR_TIMEOUT_EN defined, MAX_HOLD=4, grant to 3 with no release -> revoke after 4 GRANT cycles and a single timeout pulse; with the macro undefined -> grant held for 100+ cycles.
REQ-033 rst=1 mid-GRANT -> all outputs 0 on the next edge; the next grant with req=16'hFFFF -> gnt_id=15.

Source files
------------

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle for rr_arbiter16. "release" is a reserved word, so the
// holder's one-cycle end-of-tenure pulse is carried on rel.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic        rel;
  logic        gnt_valid;
  logic [3:0]  gnt_id;
  logic [15:0] gnt_onehot;
  logic        timeout;

  modport master (output req, rel, input gnt_valid, gnt_id, gnt_onehot, timeout);
  modport slave  (input req, rel, output gnt_valid, gnt_id, gnt_onehot, timeout);
endinterface

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with held grants and registered outputs.
// Define RR_TIMEOUT_EN to force-revoke a grant after MAX_HOLD cycles.
module rr_arbiter16 #(
  parameter int MAX_HOLD = 64
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter16_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic [3:0]  winner;
  logic        any_req;
  logic        tenure_end;
  logic        gnt_valid_q;
  logic [3:0]  gnt_id_q;
  logic [15:0] gnt_oh_q;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter16: MAX_HOLD must be 1..255");
  end

  // Downward search starting at ptr; 4-bit subtraction gives the 0 -> 15 wrap.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!any_req && bus.req[ptr - 4'(k)]) begin
        winner  = ptr - 4'(k);
        any_req = 1'b1;
      end
    end
  end

  // A holder dropping its own request ends the tenure exactly like rel.
  assign tenure_end = bus.rel | ~bus.req[gnt_id_q];

`ifdef RR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  logic       timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 4'd15;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 4'd0;
      gnt_oh_q    <= 16'd0;
`ifdef RR_TIMEOUT_EN
      hold_cnt    <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef RR_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= GRANT;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= winner;
            gnt_oh_q    <= 16'd1 << winner;
            ptr         <= winner - 4'd1;
`ifdef RR_TIMEOUT_EN
            hold_cnt    <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (tenure_end) begin
            state       <= IDLE;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= 4'd0;
            gnt_oh_q    <= 16'd0;
          end
`ifdef RR_TIMEOUT_EN
          // rel is tested first, so a release on the limit cycle suppresses timeout.
          else if (hold_cnt == HOLD_LAST) begin
            state       <= IDLE;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= 4'd0;
            gnt_oh_q    <= 16'd0;
            timeout_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
      endcase
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.gnt_onehot = gnt_oh_q;
`ifdef RR_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter16;
`ifdef RR_TIMEOUT_EN
  localparam int MH    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MH    = 64;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter16_if bus();
  rr_arbiter16 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Model: who holds, whom to search from next, and how long the tenure has lasted.
  bit m_busy;
  int m_id;
  int m_ptr;
  int m_len;
  bit m_to;

  function automatic void model_next();
    if (rst) begin
      m_busy = 0; m_id = 0; m_ptr = 15; m_len = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      for (int k = 0; k < 16; k++) begin
        automatic int i = (m_ptr - k + 16) % 16;
        if (bus.req[i]) begin
          m_busy = 1; m_id = i; m_ptr = (i + 15) % 16; m_len = 1;
          break;
        end
      end
    end else if (bus.rel || !bus.req[m_id]) begin
      m_busy = 0;
    end else if (TO_EN && m_len >= MH) begin
      m_busy = 0; m_to = 1;
    end else begin
      m_len++;
    end
  endfunction

  function automatic logic [21:0] obs();
    return {bus.gnt_valid, bus.gnt_id, bus.gnt_onehot, bus.timeout};
  endfunction

  function automatic logic [21:0] exp_out(bit v, int id, bit to);
    logic [3:0]  i4;
    logic [15:0] oh;
    i4 = v ? 4'(id) : 4'd0;
    oh = v ? (16'd1 << i4) : 16'd0;
    return {v, i4, oh, to};
  endfunction

  task automatic cyc();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.rel = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] e;
    do_reset();
    e = exp_out(0, 0, 0);
    checks++;
    if (obs() !== e) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_basic();
    logic [21:0] e;
    do_reset();
    bus.req = 16'h8001; cyc();
    e = exp_out(1, 15, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL basic_first_g15 got=%h exp=%h", obs(), e); end
    bus.rel = 1'b1; cyc();
    e = exp_out(0, 0, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL basic_idle_gap got=%h exp=%h", obs(), e); end
    bus.rel = 1'b0; cyc();
    e = exp_out(1, 0, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL basic_second_g0 got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_rotation();
    logic [21:0] e;
    do_reset();
    bus.req = 16'hFFFF; cyc();
    e = exp_out(1, 15, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL rot_start got=%h exp=%h", obs(), e); end
    for (int j = 1; j <= 16; j++) begin
      bus.rel = 1'b1; cyc();
      e = exp_out(0, 0, 0); checks++;
      if (obs() !== e) begin failures++; $display("FAIL rot_gap%0d got=%h exp=%h", j, obs(), e); end
      bus.rel = 1'b0; cyc();
      e = exp_out(1, (15 - j) & 15, 0); checks++;
      if (obs() !== e) begin failures++; $display("FAIL rot_grant%0d got=%h exp=%h", j, obs(), e); end
    end
  endtask

  task automatic test_hold_stable();
    logic [21:0] e;
    int n;
    n = (MH - 1 < 8) ? MH - 1 : 8;
    do_reset();
    bus.req = 16'h0020; cyc();
    for (int j = 0; j < n; j++) begin
      bus.req = 16'h0020 | (16'($urandom_range(0, 1)) << 2) | (16'($urandom_range(0, 1)) << 9);
      e = exp_out(1, 5, 0); checks++;
      if (obs() !== e) begin failures++; $display("FAIL hold_g5_%0d got=%h exp=%h", j, obs(), e); end
      cyc();
    end
    e = exp_out(1, 5, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL hold_g5_last got=%h exp=%h", obs(), e); end
    // On the timeout build this release lands on the limit cycle and must win.
    bus.req = 16'h0224; bus.rel = 1'b1; cyc();
    e = exp_out(0, 0, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL hold_release got=%h exp=%h", obs(), e); end
    bus.rel = 1'b0;
  endtask

  task automatic test_req_drop();
    logic [21:0] e;
    do_reset();
    bus.req = 16'h0084; cyc();
    e = exp_out(1, 7, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL drop_g7 got=%h exp=%h", obs(), e); end
    bus.req = 16'h0004; cyc();
    e = exp_out(0, 0, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL drop_ends got=%h exp=%h", obs(), e); end
    bus.req = 16'h0000; bus.rel = 1'b1; cyc();
    e = exp_out(0, 0, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL idle_release got=%h exp=%h", obs(), e); end
    bus.req = 16'h0010; bus.rel = 1'b0; cyc();
    e = exp_out(1, 4, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL drop_g4 got=%h exp=%h", obs(), e); end
    bus.req = 16'h0000; bus.rel = 1'b1; cyc();
    e = exp_out(0, 0, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL rel_and_drop got=%h exp=%h", obs(), e); end
    bus.rel = 1'b0; cyc();
    e = exp_out(0, 0, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL single_end got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_timeout();
    logic [21:0] e;
    do_reset();
    bus.req = 16'h0008; cyc();
    e = exp_out(1, 3, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL to_g3 got=%h exp=%h", obs(), e); end
`ifdef RR_TIMEOUT_EN
    for (int j = 1; j < MH; j++) begin
      cyc();
      e = exp_out(1, 3, 0); checks++;
      if (obs() !== e) begin failures++; $display("FAIL to_hold%0d got=%h exp=%h", j, obs(), e); end
    end
    cyc();
    e = exp_out(0, 0, 1); checks++;
    if (obs() !== e) begin failures++; $display("FAIL to_revoke got=%h exp=%h", obs(), e); end
    cyc();
    e = exp_out(1, 3, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL to_single_pulse got=%h exp=%h", obs(), e); end
`else
    for (int j = 1; j <= 120; j++) begin
      cyc();
      e = exp_out(1, 3, 0); checks++;
      if (obs() !== e) begin failures++; $display("FAIL to_held%0d got=%h exp=%h", j, obs(), e); end
    end
`endif
    bus.rel = 1'b1; cyc(); bus.rel = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    logic [21:0] e;
    do_reset();
    bus.req = 16'h0440; cyc();
    e = exp_out(1, 10, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL rstmid_g10 got=%h exp=%h", obs(), e); end
    rst = 1'b1; cyc();
    e = exp_out(0, 0, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL rstmid_drop got=%h exp=%h", obs(), e); end
    rst = 1'b0; bus.req = 16'hFFFF; cyc();
    e = exp_out(1, 15, 0); checks++;
    if (obs() !== e) begin failures++; $display("FAIL rstmid_g15 got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_random();
    logic [21:0] e;
    do_reset();
    for (int j = 0; j < 600; j++) begin
      bus.req = ($urandom_range(0, 4) == 0) ? 16'h0000 : (16'($urandom) | 16'($urandom));
      bus.rel = ($urandom_range(0, 5) == 0);
      cyc();
      e = exp_out(m_busy, m_id, m_to); checks++;
      if (obs() !== e) begin failures++; $display("FAIL random_cyc%0d got=%h exp=%h", j, obs(), e); end
    end
  endtask

  initial begin
    rst = 1'b1; bus.req = '0; bus.rel = 1'b0;
    m_busy = 0; m_id = 0; m_ptr = 15; m_len = 0; m_to = 0;
    test_reset();
    test_basic();
    test_rotation();
    test_hold_stable();
    test_req_drop();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
